// File: rtl/peripheral_msi_cdc_pacer_wb.sv
// ----------------------------------------------------------------------------
// peripheral_msi_cdc_pacer_wb
//
// Wishbone classic slave in the aclk domain. It buffers write data in a small
// FIFO and drains it as single-cycle aen pulses carrying adata toward the
// downstream toggle-synchroniser CDC stage. That stage cannot apply
// backpressure, so consecutive aen pulses are spaced at least GAP aclk cycles
// apart. Each pulse therefore crosses to bclk before the next one arrives.
// Wishbone reads return the current FIFO fill level.
//
// Parameters
//   DW    : data width; must match the downstream CDC stage
//   DEPTH : FIFO entries; power of two, >= 2
//   GAP   : minimum aclk cycles between rising edges of aen; >= 1
//
// Ports
//   aclk      in   clock; all logic runs on its rising edge
//   arst      in   synchronous, active-high reset
//   wb_cyc_i  in   Wishbone cycle
//   wb_stb_i  in   Wishbone strobe
//   wb_we_i   in   1 = write, 0 = read
//   wb_dat_i  in   write data
//   wb_dat_o  out  read data: FIFO level, zero-extended
//   wb_ack_o  out  single-cycle acknowledge
//   adata     out  data to the CDC stage; valid with aen, held otherwise
//   aen       out  single-cycle transfer pulse to the CDC stage
//   level     out  FIFO occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module peripheral_msi_cdc_pacer_wb #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int GAP   = 6
) (
    input  logic                     aclk,
    input  logic                     arst,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [DW-1:0]            wb_dat_i,
    output logic [DW-1:0]            wb_dat_o,
    output logic                     wb_ack_o,
    output logic [DW-1:0]            adata,
    output logic                     aen,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // Width of the spacing counter; it only ever holds values up to GAP-1.
    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ack_q, ack_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            aen_q, aen_d;
    logic [DW-1:0]   adata_q, adata_d;

    logic [DW-1:0]   mem [DEPTH];

    logic            req;
    logic            full;
    logic            push;
    logic            rd;
    logic            pop;

    // ------------------------------------------------------------------------
    // Drain FSM: IDLE pops the head whenever the FIFO is non-empty and arms
    // the spacing counter; HOLD counts down the remaining dead cycles.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch; a path that leaves a signal unassigned infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop   = 1'b1;
                    cnt_d = CW'(GAP - 1);
                    // With GAP = 1 no dead cycles are needed, so pops may
                    // run back to back from IDLE.
                    if (GAP > 1) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Wishbone slave and FIFO bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        // The ~ack_q term stops a held strobe from being accepted a second
        // time in the ack cycle.
        req  = wb_cyc_i & wb_stb_i & ~ack_q;
        // Full is taken from the registered level, so a pop in this cycle
        // frees its slot only from the next cycle on.
        full = (level_q == LW'(DEPTH));
        push = req & wb_we_i & ~full;
        rd   = req & ~wb_we_i;

        ack_d = push | rd;
        dat_d = dat_q;
        if (rd) begin
            dat_d = DW'(level_q);
        end

        // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        // A separate occupancy counter keeps full and empty unambiguous when
        // the pointers are equal.
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        aen_d   = pop;
        adata_d = pop ? mem[rd_ptr_q] : adata_q;
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (arst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            aen_q    <= 1'b0;
            adata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            aen_q    <= aen_d;
            adata_q  <= adata_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and level
    // are, so stale entries are never read and the array maps to plain RAM.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr_q] <= wb_dat_i;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign aen      = aen_q;
    assign adata    = adata_q;
    assign level    = level_q;

endmodule

// File: tb/tb_peripheral_msi_cdc_pacer_wb.sv
// ----------------------------------------------------------------------------
// tb_peripheral_msi_cdc_pacer_wb
//
// Two instances of the pacer: lane 0 with GAP = 6 and lane 1 with GAP = 1,
// both with DEPTH = 4. A behavioural model follows the bus rules each cycle.
// It keeps the FIFO as a queue, and it paces the drain with an earliest-
// next-pop time. For every cycle it pushes the expected outputs into a
// scoreboard. A monitor on the falling edge pops the scoreboard and compares
// the expected outputs with both DUTs.
// ----------------------------------------------------------------------------
module tb_peripheral_msi_cdc_pacer_wb;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int GAP0  = 6;
    localparam int GAP1  = 1;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic          arst   [2];
    logic          cyc_i  [2];
    logic          stb_i  [2];
    logic          we_i   [2];
    logic [DW-1:0] dat_i  [2];
    logic [DW-1:0] dat_o  [2];
    logic          ack_o  [2];
    logic [DW-1:0] adata  [2];
    logic          aen    [2];
    logic [LW-1:0] level  [2];

    peripheral_msi_cdc_pacer_wb #(.DW(DW), .DEPTH(DEPTH), .GAP(GAP0)) u_dut_gap6 (
        .aclk     (aclk),
        .arst     (arst[0]),
        .wb_cyc_i (cyc_i[0]),
        .wb_stb_i (stb_i[0]),
        .wb_we_i  (we_i[0]),
        .wb_dat_i (dat_i[0]),
        .wb_dat_o (dat_o[0]),
        .wb_ack_o (ack_o[0]),
        .adata    (adata[0]),
        .aen      (aen[0]),
        .level    (level[0])
    );

    peripheral_msi_cdc_pacer_wb #(.DW(DW), .DEPTH(DEPTH), .GAP(GAP1)) u_dut_gap1 (
        .aclk     (aclk),
        .arst     (arst[1]),
        .wb_cyc_i (cyc_i[1]),
        .wb_stb_i (stb_i[1]),
        .wb_we_i  (we_i[1]),
        .wb_dat_i (dat_i[1]),
        .wb_dat_o (dat_o[1]),
        .wb_ack_o (ack_o[1]),
        .adata    (adata[1]),
        .aen      (aen[1]),
        .level    (level[1])
    );

    // ------------------------------------------------------------------------
    // Scoreboard entry: expected outputs of one lane for one cycle
    // ------------------------------------------------------------------------
    typedef struct {
        int          lane;
        longint      cyc;
        bit          ack;
        bit          rd;
        logic [31:0] rdat;
        bit          aen;
        logic [31:0] adat;
        bit          rst;
        int          lvl;
    } exp_t;

    exp_t sb [$];

    int n_vec   = 0;
    int n_bad   = 0;
    int stim_to = 0;
    int seen_to = 0;

    longint cyc_n = 0;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    logic [31:0] mf0 [$];
    logic [31:0] mf1 [$];
    bit          m_ack     [2];
    longint      m_next_ok [2];

    function automatic int gap_of(input int l);
        return (l == 0) ? GAP0 : GAP1;
    endfunction

    function automatic int mf_size(input int l);
        return (l == 0) ? mf0.size() : mf1.size();
    endfunction

    function automatic void mf_push(input int l, input logic [31:0] d);
        if (l == 0) mf0.push_back(d);
        else        mf1.push_back(d);
    endfunction

    function automatic logic [31:0] mf_pop(input int l);
        if (l == 0) return mf0.pop_front();
        return mf1.pop_front();
    endfunction

    function automatic void mf_clear(input int l);
        if (l == 0) mf0.delete();
        else        mf1.delete();
    endfunction

    // The model works out what one lane shows in cycle cyc_n. It uses the
    // inputs that were present during cycle cyc_n-1.
    task automatic model_step(input int l);
        exp_t   e;
        longint t;
        bit     req, push, rd, pop;
        t      = cyc_n - 1;
        e.lane = l;
        e.cyc  = cyc_n;
        e.ack  = 1'b0;
        e.rd   = 1'b0;
        e.rdat = '0;
        e.aen  = 1'b0;
        e.adat = '0;
        e.rst  = 1'b0;
        e.lvl  = 0;
        if (arst[l]) begin
            mf_clear(l);
            m_ack[l]     = 1'b0;
            m_next_ok[l] = 0;
            e.rst        = 1'b1;
        end else begin
            req  = cyc_i[l] && stb_i[l] && !m_ack[l];
            push = req && we_i[l] && (mf_size(l) < DEPTH);
            rd   = req && !we_i[l];
            pop  = (mf_size(l) > 0) && (t >= m_next_ok[l]);
            e.ack  = push || rd;
            e.rd   = rd;
            e.rdat = 32'(mf_size(l));
            if (pop) begin
                e.aen        = 1'b1;
                e.adat       = mf_pop(l);
                m_next_ok[l] = t + gap_of(l);
            end
            if (push) mf_push(l, dat_i[l]);
            m_ack[l] = e.ack;
            e.lvl    = mf_size(l);
        end
        sb.push_back(e);
    endtask

    initial begin
        m_ack[0] = 1'b0; m_ack[1] = 1'b0;
        m_next_ok[0] = 0; m_next_ok[1] = 0;
        forever begin
            @(posedge aclk);
            cyc_n++;
            for (int l = 0; l < 2; l++) model_step(l);
        end
    end

    // ------------------------------------------------------------------------
    // Monitor / comparator
    // ------------------------------------------------------------------------
    task automatic check(input string name, input int l,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d cycle %0d: got 0x%08h, expected 0x%08h",
                     name, l, cyc_n, act, exp);
        end
    endtask

    task automatic compare(input exp_t e);
        int l;
        l = e.lane;
        check("ack", l, 32'(ack_o[l]), 32'(e.ack));
        check("aen", l, 32'(aen[l]), 32'(e.aen));
        if (e.aen) check("adata", l, adata[l], e.adat);
        if (e.ack && e.rd) check("rdata", l, dat_o[l], e.rdat);
        if (e.rst) begin
            check("rst_adata", l, adata[l], 32'h0);
            check("rst_dat_o", l, dat_o[l], 32'h0);
        end
        check("level", l, 32'(level[l]), 32'(e.lvl));
        check("level_range", l, 32'(level[l] <= LW'(DEPTH)), 32'd1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
                e = sb.pop_front();
                compare(e);
            end
            check("stim_timeout", -1, 32'(stim_to), 32'(seen_to));
            seen_to = stim_to;
        end
    end

    // ------------------------------------------------------------------------
    // Bus stimulus (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------------
    task automatic wb_idle(input int l, input int n);
        cyc_i[l] = 1'b0;
        stb_i[l] = 1'b0;
        we_i[l]  = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic wb_xfer(input int l, input bit we, input logic [31:0] d);
        int n;
        cyc_i[l] = 1'b1;
        stb_i[l] = 1'b1;
        we_i[l]  = we;
        dat_i[l] = d;
        n = 0;
        do begin
            @(posedge aclk);
            #1;
            n++;
        end while (!ack_o[l] && n < 200);
        if (!ack_o[l]) stim_to++;
    endtask

    task automatic wb_write(input int l, input logic [31:0] d);
        wb_xfer(l, 1'b1, d);
    endtask

    task automatic wb_read(input int l);
        wb_xfer(l, 1'b0, $urandom);
    endtask

    // Write whose cycle is abandoned one cycle after it is presented.
    task automatic wb_drop_write(input int l, input logic [31:0] d);
        cyc_i[l] = 1'b1;
        stb_i[l] = 1'b1;
        we_i[l]  = 1'b1;
        dat_i[l] = d;
        @(posedge aclk);
        #1;
        cyc_i[l] = 1'b0;
        stb_i[l] = 1'b0;
    endtask

    initial begin
        for (int l = 0; l < 2; l++) begin
            arst[l]  = 1'b1;
            cyc_i[l] = 1'b0;
            stb_i[l] = 1'b0;
            we_i[l]  = 1'b0;
            dat_i[l] = '0;
        end
        repeat (3) @(posedge aclk);
        #1;
        arst[0] = 1'b0;
        arst[1] = 1'b0;
        wb_idle(0, 2);

        // Single write into an idle FIFO.
        wb_write(0, 32'hA5A5_0001);
        wb_idle(0, 10);

        // Five back-to-back writes, then a longer burst that fills the FIFO.
        for (int i = 1; i <= 5; i++) wb_write(0, 32'(i));
        wb_idle(0, 40);
        for (int i = 0; i < 8; i++) wb_write(0, 32'h0B00_0000 + 32'(i));
        wb_idle(0, 60);

        // Read while a burst is still draining.
        for (int i = 0; i < 4; i++) wb_write(0, 32'h0000_0100 + 32'(i));
        wb_read(0);
        wb_read(0);
        wb_idle(0, 40);

        // GAP = 1: back-to-back pulses.
        for (int i = 0; i < 4; i++) wb_write(1, 32'hC0DE_0000 + 32'(i));
        wb_idle(1, 10);

        // Reset while entries are queued and the drain is holding off.
        for (int i = 0; i < 3; i++) wb_write(0, 32'hDEAD_0000 + 32'(i));
        cyc_i[0] = 1'b0;
        stb_i[0] = 1'b0;
        arst[0]  = 1'b1;
        @(posedge aclk);
        #1;
        arst[0] = 1'b0;
        wb_idle(0, 20);
        wb_write(0, 32'hBEEF_0005);
        wb_idle(0, 10);

        // Cycle dropped right after an accepted write.
        wb_drop_write(0, 32'h0000_1234);
        wb_idle(0, 10);

        // Randomised traffic on both lanes.
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 150; k++) begin
                int op;
                op = int'($urandom_range(0, 9));
                if (op <= 5)      wb_write(l, $urandom);
                else if (op <= 7) wb_read(l);
                else if (op == 8) wb_idle(l, int'($urandom_range(1, 8)));
                else              wb_drop_write(l, $urandom);
            end
            wb_idle(l, 40);
        end

        wb_idle(0, 20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
